jtag_tap: RTL and testbench

JTAG_TAP -- requirements
Module: jtag_tap

---
 rtl/jtag_tap.sv | 200 ++++++++++++++++++++
 tb/tb_jtag_tap.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller running entirely in the system clock domain.
// JTAG pins are oversampled; IDCODE, BYPASS and a 32-bit user data register are supported.
module jtag_tap #(
  parameter logic [31:0]       IDCODE  = 32'h10000DB3,
  parameter int unsigned       IR_LEN  = 5,
  parameter logic [IR_LEN-1:0] USER_IR = 5'h10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        jtag_TCK,
  input  logic        jtag_TMS,
  input  logic        jtag_TDI,
  input  logic        jtag_TRSTn,
  output logic        jtag_TDO_data,
  output logic        jtag_TDO_driven,
  input  logic [31:0] user_dr_in,
  output logic [31:0] user_dr_out,
  output logic        user_update,
  output logic [3:0]  tap_state
);

  localparam logic [3:0] S_TLR   = 4'd0;
  localparam logic [3:0] S_RTI   = 4'd1;
  localparam logic [3:0] S_SELDR = 4'd2;
  localparam logic [3:0] S_CAPDR = 4'd3;
  localparam logic [3:0] S_SHDR  = 4'd4;
  localparam logic [3:0] S_EX1DR = 4'd5;
  localparam logic [3:0] S_PAUDR = 4'd6;
  localparam logic [3:0] S_EX2DR = 4'd7;
  localparam logic [3:0] S_UPDDR = 4'd8;
  localparam logic [3:0] S_SELIR = 4'd9;
  localparam logic [3:0] S_CAPIR = 4'd10;
  localparam logic [3:0] S_SHIR  = 4'd11;
  localparam logic [3:0] S_EX1IR = 4'd12;
  localparam logic [3:0] S_PAUIR = 4'd13;
  localparam logic [3:0] S_EX2IR = 4'd14;
  localparam logic [3:0] S_UPDIR = 4'd15;

  localparam logic [IR_LEN-1:0] IR_IDCODE = {{(IR_LEN-1){1'b0}}, 1'b1};

  logic              r_tck_s1, r_tck_s2, r_tck_hist;
  logic              r_tms_s1, r_tms_s2;
  logic              r_tdi_s1, r_tdi_s2;
  logic              r_trst_s1, r_trst_s2;
  logic [1:0]        r_fill;
  logic [3:0]        r_state;
  logic [3:0]        w_next;
  logic [IR_LEN-1:0] r_ir;
  logic [IR_LEN-1:0] r_ir_shift;
  logic [31:0]       r_id_dr;
  logic [31:0]       r_user_dr;
  logic              r_bypass;
  logic              w_armed;
  logic              w_trst_n;
  logic              w_rise;
  logic              w_fall;
  logic              w_sel_id;
  logic              w_sel_user;
  logic              w_dr_lsb;

  // Edge detection stays disarmed until the history flop holds a real pin sample,
  // so a TCK held high across reset is not mistaken for a rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tck_s1   <= 1'b0;
      r_tck_s2   <= 1'b0;
      r_tck_hist <= 1'b0;
      r_tms_s1   <= 1'b0;
      r_tms_s2   <= 1'b0;
      r_tdi_s1   <= 1'b0;
      r_tdi_s2   <= 1'b0;
      r_trst_s1  <= 1'b1;
      r_trst_s2  <= 1'b1;
      r_fill     <= '0;
    end else begin
      r_tck_s1   <= jtag_TCK;
      r_tck_s2   <= r_tck_s1;
      r_tck_hist <= r_tck_s2;
      r_tms_s1   <= jtag_TMS;
      r_tms_s2   <= r_tms_s1;
      r_tdi_s1   <= jtag_TDI;
      r_tdi_s2   <= r_tdi_s1;
      r_trst_s1  <= jtag_TRSTn;
      r_trst_s2  <= r_trst_s1;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  assign w_armed  = (r_fill == 2'd3);
  assign w_trst_n = r_trst_s2;
  assign w_rise   = w_armed &  r_tck_s2 & ~r_tck_hist;
  assign w_fall   = w_armed & ~r_tck_s2 &  r_tck_hist;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:   w_next = r_tms_s2 ? S_TLR   : S_RTI;
      S_RTI:   w_next = r_tms_s2 ? S_SELDR : S_RTI;
      S_SELDR: w_next = r_tms_s2 ? S_SELIR : S_CAPDR;
      S_CAPDR: w_next = r_tms_s2 ? S_EX1DR : S_SHDR;
      S_SHDR:  w_next = r_tms_s2 ? S_EX1DR : S_SHDR;
      S_EX1DR: w_next = r_tms_s2 ? S_UPDDR : S_PAUDR;
      S_PAUDR: w_next = r_tms_s2 ? S_EX2DR : S_PAUDR;
      S_EX2DR: w_next = r_tms_s2 ? S_UPDDR : S_SHDR;
      S_UPDDR: w_next = r_tms_s2 ? S_SELDR : S_RTI;
      S_SELIR: w_next = r_tms_s2 ? S_TLR   : S_CAPIR;
      S_CAPIR: w_next = r_tms_s2 ? S_EX1IR : S_SHIR;
      S_SHIR:  w_next = r_tms_s2 ? S_EX1IR : S_SHIR;
      S_EX1IR: w_next = r_tms_s2 ? S_UPDIR : S_PAUIR;
      S_PAUIR: w_next = r_tms_s2 ? S_EX2IR : S_PAUIR;
      S_EX2IR: w_next = r_tms_s2 ? S_UPDIR : S_SHIR;
      S_UPDIR: w_next = r_tms_s2 ? S_SELDR : S_RTI;
      default: w_next = S_TLR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_TLR;
      r_ir       <= IR_IDCODE;
      r_ir_shift <= '0;
    end else if (!w_trst_n) begin
      r_state <= S_TLR;
      r_ir    <= IR_IDCODE;
    end else if (w_rise) begin
      r_state <= w_next;
      case (r_state)
        S_CAPIR: r_ir_shift <= IR_IDCODE;
        S_SHIR:  r_ir_shift <= {r_tdi_s2, r_ir_shift[IR_LEN-1:1]};
        S_UPDIR: r_ir       <= r_ir_shift;
        default: ;
      endcase
      if (w_next == S_TLR) r_ir <= IR_IDCODE;
    end
  end

  // IDCODE takes precedence should USER_IR ever be configured to the same code.
  assign w_sel_id   = (r_ir == IR_IDCODE);
  assign w_sel_user = !w_sel_id && (r_ir == USER_IR);
  assign w_dr_lsb   = w_sel_id ? r_id_dr[0] : (w_sel_user ? r_user_dr[0] : r_bypass);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_id_dr   <= '0;
      r_user_dr <= '0;
      r_bypass  <= 1'b0;
    end else if (w_trst_n && w_rise) begin
      case (r_state)
        S_CAPDR: begin
          if (w_sel_id)        r_id_dr   <= IDCODE;
          else if (w_sel_user) r_user_dr <= user_dr_in;
          else                 r_bypass  <= 1'b0;
        end
        S_SHDR: begin
          if (w_sel_id)        r_id_dr   <= {r_tdi_s2, r_id_dr[31:1]};
          else if (w_sel_user) r_user_dr <= {r_tdi_s2, r_user_dr[31:1]};
          else                 r_bypass  <= r_tdi_s2;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      if (w_trst_n && w_rise && (r_state == S_UPDDR) && w_sel_user) begin
        user_dr_out <= r_user_dr;
        user_update <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jtag_TDO_data   <= 1'b0;
      jtag_TDO_driven <= 1'b0;
    end else if (!w_trst_n) begin
      jtag_TDO_driven <= 1'b0;
    end else if (w_fall) begin
      case (r_state)
        S_SHIR: begin
          jtag_TDO_data   <= r_ir_shift[0];
          jtag_TDO_driven <= 1'b1;
        end
        S_SHDR: begin
          jtag_TDO_data   <= w_dr_lsb;
          jtag_TDO_driven <= 1'b1;
        end
        default: jtag_TDO_driven <= 1'b0;
      endcase
    end
  end

  assign tap_state = r_state;

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: drives slow TCK cycles, queues expected TDO bits per scan
// and compares them as each bit appears.
module tb_jtag_tap;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        trst_n = 1'b1;
  logic [31:0] user_dr_in = '0;
  logic        tdo_data;
  logic        tdo_drv;
  logic [31:0] user_dr_out;
  logic        user_update;
  logic [3:0]  tap_state;

  int n_checks = 0;
  int n_fail = 0;
  int n_upd = 0;
  logic exp_q[$];

  always #5 clock = ~clock;

  always @(negedge clock) if (user_update) n_upd++;

  jtag_tap #(
    .IDCODE (32'h10000DB3),
    .IR_LEN (5),
    .USER_IR(5'h10)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .jtag_TCK       (tck),
    .jtag_TMS       (tms),
    .jtag_TDI       (tdi),
    .jtag_TRSTn     (trst_n),
    .jtag_TDO_data  (tdo_data),
    .jtag_TDO_driven(tdo_drv),
    .user_dr_in     (user_dr_in),
    .user_dr_out    (user_dr_out),
    .user_update    (user_update),
    .tap_state      (tap_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One full TCK period; TDO is sampled once the falling edge has been processed.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic o_tdo, output logic o_drv);
    @(negedge clock);
    tms = t_ms;
    tdi = t_di;
    repeat (2) @(negedge clock);
    tck = 1'b1;
    repeat (4) @(negedge clock);
    tck = 1'b0;
    repeat (4) @(negedge clock);
    o_tdo = tdo_data;
    o_drv = tdo_drv;
  endtask

  // From RTI: scan n bits of din (LSB first) through IR or DR and return to RTI.
  task automatic scan(input logic is_ir, input int n, input logic [31:0] din,
                      input logic [31:0] exp, input string tag);
    logic t, d, e;
    for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
    tck_cycle(1'b1, 1'b0, t, d);
    if (is_ir) tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check({tag, " shift state"}, 32'(tap_state), is_ir ? 32'd11 : 32'd4);
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, " tdo"}, 32'(t), 32'(e));
      check({tag, " tdo driven"}, 32'(d), 32'd1);
      tck_cycle((i == n - 1), din[i], t, d);
    end
    check({tag, " exit1 tdo driven"}, 32'(d), 32'd0);
    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check({tag, " back in rti"}, 32'(tap_state), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic t, d;
    int upd0;

    @(negedge clock);
    check("reset tap_state", 32'(tap_state), 32'd0);
    check("reset tdo_data", 32'(tdo_data), 32'd0);
    check("reset tdo_driven", 32'(tdo_drv), 32'd0);
    check("reset user_dr_out", user_dr_out, 32'd0);
    check("reset user_update", 32'(user_update), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clock);

    // Latency: new state appears three clocks after the TCK pin rises.
    tms = 1'b0;
    repeat (2) @(negedge clock);
    tck = 1'b1;
    repeat (2) @(negedge clock);
    check("rise latency 2 clk", 32'(tap_state), 32'd0);
    @(negedge clock);
    check("rise latency 3 clk", 32'(tap_state), 32'd1);
    repeat (2) @(negedge clock);
    tck = 1'b0;
    repeat (5) @(negedge clock);

    scan(1'b0, 32, 32'h0, 32'h10000DB3, "idcode");

    scan(1'b1, 5, 32'h1F, 32'h01, "ir bypass");
    scan(1'b0, 4, 32'hD, 32'hA, "bypass");

    user_dr_in = 32'h12345678;
    scan(1'b1, 5, 32'h10, 32'h01, "ir user");
    upd0 = n_upd;
    scan(1'b0, 32, 32'hCAFEF00D, 32'h12345678, "user dr");
    check("user_dr_out", user_dr_out, 32'hCAFEF00D);
    check("user_update pulses", 32'(n_upd - upd0), 32'd1);

    // Five TMS=1 from ShIR; the UpdIR on the way leaves IR=0, TLR must restore IDCODE.
    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check("in shift-ir", 32'(tap_state), 32'd11);
    upd0 = n_upd;
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t, d);
    check("tms reset tap_state", 32'(tap_state), 32'd0);
    check("tms reset user_dr_out", user_dr_out, 32'hCAFEF00D);
    check("tms reset no update", 32'(n_upd - upd0), 32'd0);
    tck_cycle(1'b0, 1'b0, t, d);
    scan(1'b0, 32, 32'h0, 32'h10000DB3, "idcode after tlr");

    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check("pre-trst state", 32'(tap_state), 32'd4);
    check("pre-trst driven", 32'(d), 32'd1);
    @(negedge clock);
    trst_n = 1'b0;
    repeat (2) @(negedge clock);
    check("trst 2 clk state", 32'(tap_state), 32'd4);
    @(negedge clock);
    check("trst 3 clk state", 32'(tap_state), 32'd0);
    check("trst tdo_driven", 32'(tdo_drv), 32'd0);
    check("trst user_dr_out", user_dr_out, 32'hCAFEF00D);
    @(negedge clock);
    trst_n = 1'b1;
    repeat (5) @(negedge clock);
    tck_cycle(1'b0, 1'b0, t, d);
    scan(1'b0, 32, 32'h0, 32'h10000DB3, "idcode after trst");

    // Reach Pause-IR with TDO data left at 1, then pulse reset.
    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b1, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check("shift-ir first tdo", 32'(t), 32'd1);
    tck_cycle(1'b1, 1'b1, t, d);
    tck_cycle(1'b0, 1'b0, t, d);
    check("pause-ir state", 32'(tap_state), 32'd13);
    check("pause-ir tdo_data held", 32'(tdo_data), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset tap_state", 32'(tap_state), 32'd0);
    check("mid reset tdo_data", 32'(tdo_data), 32'd0);
    check("mid reset tdo_driven", 32'(tdo_drv), 32'd0);
    check("mid reset user_dr_out", user_dr_out, 32'd0);
    check("mid reset user_update", 32'(user_update), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    tck_cycle(1'b0, 1'b0, t, d);
    scan(1'b0, 32, 32'h0, 32'h10000DB3, "idcode after reset");
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
